uwasic_spi_pwm_top: RTL and testbench
=====================================

Name: uwasic_spi_pwm_top

Overview:
- Tiny Tapeout onboarding user top: SPI-mode-0 write-only peripheral drives a 5-byte register file.
- Register file controls 16 output pins (uo_out[7:0], uio_out[7:0]): per-pin static enable plus per-pin PWM select, sharing one 8-bit-duty PWM generator (~3 kHz at 10 MHz clk).
- pwm_bit0 exposes the raw PWM waveform for probing.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter tick; period = 256*PRESCALE = 3328 clk.
- SYNC_STAGES, 2, flop stages synchronising SCLK/COPI/nCS into clk.
- MAX_ADDR, 4, highest writable register address.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- ena  in  1  design-selected; ignored, no effect.
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS (active low); [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  output pins 7:0.
- uio_out  out  8  output pins 15:8.
- uio_oe  out  8  constant 8'hFF (all bidir pins outputs).
- pwm_bit0  out  1  raw PWM waveform, ungated by enables.

Behaviour:
- Reset (rst=1 at clk edge): all registers 0x00, synchronisers cleared (nCS sync to 1), bit counter 0, PWM prescaler/counter 0; uo_out=uio_out=0, pwm_bit0=0.
- Registers: 0x00 out_en[7:0], 0x01 out_en[15:8], 0x02 pwm_en[7:0], 0x03 pwm_en[15:8], 0x04 duty[7:0].
- SPI: inputs via SYNC_STAGES synchronisers; SCLK rising edge detected from last two synced samples; sampled only while synced nCS=0.
- Frame 16 bits MSB first: bit15 R/W (1=write), bits14:8 address (7 bits), bits7:0 data.
- Shift COPI on each SCLK rise; bits beyond 16 ignored (counter saturates at 16).
- Commit on synced nCS rising edge: exactly 16 bits, R/W=1, addr<=MAX_ADDR → write data; otherwise discard. Reads / addr>4 / short or long frames: no state change, no reply output.
- nCS falling edge clears shift reg and bit counter; rst mid-frame aborts frame.
- Latency: register updates within SYNC_STAGES+2 clk after nCS rise.
- PWM: prescaler 0..PRESCALE-1; tick at wrap increments 8-bit counter (wraps 255→0).
- pwm = (duty==8'hFF) ? 1 : (counter < duty); duty=0 → constant 0.
- Duty changes take effect immediately (no period sync).
- Pin i: out_en[i]=0 → 0; out_en[i]=1, pwm_en[i]=0 → 1; both 1 → pwm. All pins share one waveform, phase-aligned.
- Outputs registered: 1-clk latency from register/pwm to pins.
- pwm_bit0 = pwm (registered), regardless of enables.

Decomposition:
- Package uwasic_pkg: address constants ADDR_OUT_LO..ADDR_DUTY, FRAME_BITS=16, PRESCALE default.
- Sub-modules: spi_peripheral (sync, shift, commit, register file) and pwm_peripheral (prescaler, counter, compare, pin gating); top only wires and ties uio_oe.

Test Plan:
- Reset then idle 1000 clk → uo_out=uio_out=0, uio_oe=0xFF, pwm_bit0 toggles only if duty≠0 (stays 0).
- Write 0x00←0xF0, 0x01←0xCC (SCLK 100 kHz, clk 10 MHz) → uo_out=0xF0, uio_out=0xCC.
- Read frame (R/W=0) addr 0x00 data 0xFF, and write addr 0x30 data 0xAA → registers unchanged.
- out_en[0]=1, pwm_en[0]=1, duty=0x80 → uo_out[0] period 3328 clk (±1), high 1664 clk (50%); duty 0x00 → constant 0; 0xFF → constant 1.
- 12-bit frame then nCS high → no write; next valid 16-bit frame commits correctly.
- Assert rst mid-frame after 8 bits → frame discarded, all outputs 0 next clk.

Source files
------------

// File: rtl/uwasic_pkg.sv
// Shared constants and helpers for the SPI-controlled PWM pin driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control; SPI is write-only and fire-and-forget).
// Contents: register address map, SPI frame length, default parameters and the
// frame-acceptance helper used by the SPI register file.
package uwasic_pkg;

  // Register address map
  localparam logic [6:0] ADDR_OUT_LO = 7'h00;  // out_en[7:0]
  localparam logic [6:0] ADDR_OUT_HI = 7'h01;  // out_en[15:8]
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;  // pwm_en[7:0]
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;  // pwm_en[15:8]
  localparam logic [6:0] ADDR_DUTY   = 7'h04;  // duty[7:0]

  // SPI frame: R/W bit, 7-bit address, 8-bit data, MSB first
  localparam int FRAME_BITS  = 16;
  localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);

  // Default parameters
  localparam int PRESCALE_DEFAULT    = 13;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int MAX_ADDR_DEFAULT    = 4;

  // A frame is committed only if it carried exactly FRAME_BITS bits, is a
  // write, and targets an implemented register.
  function automatic logic frame_commits(input logic [BIT_CNT_W-1:0] bit_cnt,
                                         input logic                 overrun,
                                         input logic [15:0]          frame,
                                         input int                   max_addr);
    return (bit_cnt == BIT_CNT_W'(FRAME_BITS)) && !overrun && frame[15] &&
           (int'(frame[14:8]) <= max_addr);
  endfunction

endpackage

// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator with per-pin static/PWM gating onto 16 registered outputs.
// Latency: 1 clk from register/counter state to pins.
// Backpressure: none; free-running.
// Ports: clk/rst (sync active-high), i_out_en/i_pwm_en[15:0], i_duty[7:0],
//        o_pins[15:0] gated outputs, o_pwm raw registered waveform.
module pwm_peripheral
  import uwasic_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_out_en,
  input  logic [15:0] i_pwm_en,
  input  logic [7:0]  i_duty,
  output logic [15:0] o_pins,
  output logic        o_pwm
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] r_presc;
  logic [7:0]      r_cnt;
  logic [15:0]     r_pins;
  logic            r_pwm;

  logic            w_pwm;
  logic [15:0]     w_pins;

  // Prescaler wraps at PRESCALE-1; each wrap advances the duty counter,
  // giving a 256*PRESCALE clk period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else if (r_presc == PS_W'(PRESCALE - 1)) begin
      r_presc <= '0;
      r_cnt   <= r_cnt + 8'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Full-scale duty must be constantly high; a plain compare would drop low
  // for the one count where r_cnt == 255.
  assign w_pwm  = (i_duty == 8'hFF) | (r_cnt < i_duty);
  assign w_pins = i_out_en & (~i_pwm_en | {16{w_pwm}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pins <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_pins <= w_pins;
      r_pwm  <= w_pwm;
    end
  end

  assign o_pins = r_pins;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register file: synchronises SCLK/COPI/nCS, shifts a 16-bit frame, commits on nCS rise.
// Latency: register update SYNC_STAGES+1 clk after the nCS rising edge reaches i_ncs.
// Backpressure: none; malformed, read or out-of-range frames are silently dropped.
// Ports: clk/rst (sync active-high), i_sclk/i_copi/i_ncs raw SPI pins,
//        o_out_en[15:0], o_pwm_en[15:0], o_duty[7:0] register contents.
module spi_peripheral
  import uwasic_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,  // must be >= 2
  parameter int MAX_ADDR    = MAX_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sclk,
  input  logic        i_copi,
  input  logic        i_ncs,
  output logic [15:0] o_out_en,
  output logic [15:0] o_pwm_en,
  output logic [7:0]  o_duty
);

  // SCLK and nCS chains carry one extra stage so the two newest synchronised
  // samples are available for edge detection. COPI only needs to line up
  // with the current SCLK sample.
  logic [SYNC_STAGES:0]   r_sclk_sh;
  logic [SYNC_STAGES:0]   r_ncs_sh;
  logic [SYNC_STAGES-1:0] r_copi_sh;

  logic [15:0]            r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_overrun;   // a clock edge arrived after the 16th bit
  logic [15:0]            r_out_en;
  logic [15:0]            r_pwm_en;
  logic [7:0]             r_duty;

  logic w_sclk, w_sclk_prev, w_copi, w_ncs, w_ncs_prev;
  logic w_sclk_rise, w_ncs_fall, w_ncs_rise, w_commit;

  assign w_sclk      = r_sclk_sh[SYNC_STAGES-1];
  assign w_sclk_prev = r_sclk_sh[SYNC_STAGES];
  assign w_ncs       = r_ncs_sh[SYNC_STAGES-1];
  assign w_ncs_prev  = r_ncs_sh[SYNC_STAGES];
  assign w_copi      = r_copi_sh[SYNC_STAGES-1];

  // SCLK edges only count while the synchronised chip select is asserted.
  assign w_sclk_rise = w_sclk & ~w_sclk_prev & ~w_ncs;
  assign w_ncs_fall  = ~w_ncs & w_ncs_prev;
  assign w_ncs_rise  = w_ncs & ~w_ncs_prev;
  assign w_commit    = w_ncs_rise && frame_commits(r_bit_cnt, r_overrun, r_shift, MAX_ADDR);

  // Input synchronisers; nCS resets to the idle (deasserted) level so a
  // reset never produces a spurious frame edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sh <= '0;
      r_copi_sh <= '0;
      r_ncs_sh  <= '1;
    end else begin
      r_sclk_sh <= {r_sclk_sh[SYNC_STAGES-1:0], i_sclk};
      r_copi_sh <= {r_copi_sh[SYNC_STAGES-2:0], i_copi};
      r_ncs_sh  <= {r_ncs_sh[SYNC_STAGES-1:0], i_ncs};
    end
  end

  // Frame shifter. The counter saturates at FRAME_BITS; any further SCLK
  // edge marks the frame as too long so it is discarded rather than
  // committing the first 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (w_ncs_fall) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
    end else if (w_sclk_rise) begin
      if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS)) begin
        r_overrun <= 1'b1;
      end else begin
        r_shift   <= {r_shift[14:0], w_copi};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en <= '0;
      r_pwm_en <= '0;
      r_duty   <= '0;
    end else if (w_commit) begin
      case (r_shift[14:8])
        ADDR_OUT_LO: r_out_en[7:0]  <= r_shift[7:0];
        ADDR_OUT_HI: r_out_en[15:8] <= r_shift[7:0];
        ADDR_PWM_LO: r_pwm_en[7:0]  <= r_shift[7:0];
        ADDR_PWM_HI: r_pwm_en[15:8] <= r_shift[7:0];
        ADDR_DUTY:   r_duty         <= r_shift[7:0];
        default:     ;
      endcase
    end
  end

  assign o_out_en = r_out_en;
  assign o_pwm_en = r_pwm_en;
  assign o_duty   = r_duty;

endmodule

// File: rtl/uwasic_spi_pwm_top.sv
// Tiny Tapeout user top: SPI write-only register file driving 16 pins with static enable or shared PWM.
// Latency: pins update within SYNC_STAGES+2 clk of nCS rising; PWM to pins 1 clk.
// Backpressure: none.
// Ports: clk, rst (sync active-high), ena (ignored), ui_in[0]=SCLK [1]=COPI [2]=nCS,
//        uio_in (unused), uo_out = pins 7:0, uio_out = pins 15:8, uio_oe = 8'hFF, pwm_bit0 raw PWM.
module uwasic_spi_pwm_top
  import uwasic_pkg::*;
#(
  parameter int PRESCALE    = PRESCALE_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int MAX_ADDR    = MAX_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       pwm_bit0
);

  logic [15:0] w_out_en;
  logic [15:0] w_pwm_en;
  logic [7:0]  w_duty;
  logic [15:0] w_pins;

  // Inputs the design deliberately ignores.
  logic w_unused;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  spi_peripheral #(
    .SYNC_STAGES (SYNC_STAGES),
    .MAX_ADDR    (MAX_ADDR)
  ) u_spi (
    .clk      (clk),
    .rst      (rst),
    .i_sclk   (ui_in[0]),
    .i_copi   (ui_in[1]),
    .i_ncs    (ui_in[2]),
    .o_out_en (w_out_en),
    .o_pwm_en (w_pwm_en),
    .o_duty   (w_duty)
  );

  pwm_peripheral #(
    .PRESCALE (PRESCALE)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .i_out_en (w_out_en),
    .i_pwm_en (w_pwm_en),
    .i_duty   (w_duty),
    .o_pins   (w_pins),
    .o_pwm    (pwm_bit0)
  );

  assign uo_out  = w_pins[7:0];
  assign uio_out = w_pins[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_spi_pwm_top.sv
// Directed bench for uwasic_spi_pwm_top: SPI frames at 100 kHz against a 10 MHz clock.
// A register model predicts pin states; expectations are queued when a frame is sent
// and popped when the outputs are sampled.
module tb_uwasic_spi_pwm_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       sclk, copi, ncs;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic       pwm_bit0;

  assign ui_in = {5'b10101, ncs, copi, sclk};

  uwasic_spi_pwm_top dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .ui_in    (ui_in),
    .uio_in   (uio_in),
    .uo_out   (uo_out),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe),
    .pwm_bit0 (pwm_bit0)
  );

  always #50 clk = ~clk;  // 10 MHz

  int checks   = 0;
  int failures = 0;

  // Register model
  logic [15:0] m_out_en = '0;
  logic [15:0] m_pwm_en = '0;
  logic [7:0]  m_duty   = '0;

  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK period = 100 clk (100 kHz); COPI set while SCLK is low.
  task automatic spi_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(50);
      sclk = 1'b1;
      wait_clk(50);
      sclk = 1'b0;
    end
    copi = 1'b0;
  endtask

  // Model of frame acceptance: exactly 16 bits, write, address 0..4.
  task automatic model_frame(input logic [31:0] v, input int n);
    if (n == 16 && v[15] && v[14:8] <= 7'd4) begin
      case (v[14:8])
        7'd0: m_out_en[7:0]  = v[7:0];
        7'd1: m_out_en[15:8] = v[7:0];
        7'd2: m_pwm_en[7:0]  = v[7:0];
        7'd3: m_pwm_en[15:8] = v[7:0];
        default: m_duty      = v[7:0];
      endcase
    end
  endtask

  // Expected pins only meaningful while PWM-enabled pins see a static
  // waveform (duty 0x00 or 0xFF) or no pin is PWM-enabled.
  task automatic push_expect(input string tag);
    exp_t e;
    logic lvl;
    lvl   = (m_duty == 8'hFF);
    e.tag = tag;
    e.uo  = m_out_en[7:0]  & (~m_pwm_en[7:0]  | {8{lvl}});
    e.uio = m_out_en[15:8] & (~m_pwm_en[15:8] | {8{lvl}});
    sb.push_back(e);
  endtask

  task automatic spi_frame(input string tag, input logic [31:0] v, input int n);
    ncs = 1'b0;
    wait_clk(50);
    spi_bits(v, n);
    wait_clk(50);
    ncs = 1'b1;
    model_frame(v, n);
    push_expect(tag);
    wait_clk(20);
  endtask

  task automatic pop_check();
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, "_uo"},  {24'h0, uo_out},  {24'h0, e.uo});
    check({e.tag, "_uio"}, {24'h0, uio_out}, {24'h0, e.uio});
  endtask

  task automatic write_reg(input string tag, input logic [6:0] addr, input logic [7:0] data);
    spi_frame(tag, {16'h0, 1'b1, addr, data}, 16);
    pop_check();
  endtask

  // Count samples over n clk where uo_out[0] / pwm_bit0 equal lvl.
  task automatic count_level(input int n, input logic lvl, output int pin_hits, output int raw_hits);
    pin_hits = 0;
    raw_hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0] === lvl) pin_hits++;
      if (pwm_bit0 === lvl)  raw_hits++;
    end
  endtask

  initial begin
    int pin_hits, raw_hits, oe_bad;
    int t, high, low;
    rst = 1'b1; ena = 1'b1; uio_in = 8'h5A;
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_uo",   {24'h0, uo_out},  32'h00);
    check("reset_uio",  {24'h0, uio_out}, 32'h00);
    check("reset_oe",   {24'h0, uio_oe},  32'hFF);
    check("reset_pwm",  {31'h0, pwm_bit0}, 32'h0);

    // Idle: nothing moves with duty 0
    pin_hits = 0; raw_hits = 0; oe_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (uo_out !== 8'h00 || uio_out !== 8'h00) pin_hits++;
      if (pwm_bit0 !== 1'b0) raw_hits++;
      if (uio_oe !== 8'hFF) oe_bad++;
    end
    check("idle_pins_nonzero", pin_hits, 0);
    check("idle_pwm_high",     raw_hits, 0);
    check("idle_oe_bad",       oe_bad,   0);

    // Static enables
    write_reg("wr_out_lo", 7'h00, 8'hF0);
    write_reg("wr_out_hi", 7'h01, 8'hCC);

    // Read frame, out-of-range and aliased addresses: no change
    spi_frame("read_ignored", {16'h0, 1'b0, 7'h00, 8'hFF}, 16);
    pop_check();
    spi_frame("addr30_ignored", {16'h0, 1'b1, 7'h30, 8'hAA}, 16);
    pop_check();
    spi_frame("addr40_ignored", {16'h0, 1'b1, 7'h40, 8'h00}, 16);
    pop_check();

    // Short frame discarded, next valid frame commits
    spi_frame("short_frame", {20'h0, 12'h80F}, 12);
    pop_check();
    write_reg("after_short", 7'h01, 8'h3C);

    // Long frame discarded
    spi_frame("long_frame", {15'h0, 1'b1, 7'h00, 8'h0F, 1'b1}, 17);
    pop_check();

    // PWM on pin 0 at 50 %
    write_reg("pin0_static", 7'h00, 8'h01);
    spi_frame("pwm_en0", {16'h0, 1'b1, 7'h02, 8'h01}, 16);
    sb.delete();  // pin 0 now follows the PWM waveform; measured below instead
    spi_frame("duty80", {16'h0, 1'b1, 7'h04, 8'h80}, 16);
    sb.delete();
    t = 0;
    while (uo_out[0] !== 1'b0 && t < 10000) begin @(negedge clk); t++; end
    while (uo_out[0] !== 1'b1 && t < 10000) begin @(negedge clk); t++; end
    check("pwm_edge_timeout", (t >= 10000), 0);
    high = 0; low = 0;
    while (uo_out[0] === 1'b1 && high < 10000) begin @(negedge clk); high++; end
    while (uo_out[0] === 1'b0 && low < 10000)  begin @(negedge clk); low++;  end
    check("pwm_high_clk", high, 1664);
    check("pwm_period_in_tol", ((high + low) >= 3327 && (high + low) <= 3329), 1);
    check("pwm_uio_static", {24'h0, uio_out}, 32'h3C);

    // Duty 0 -> constant low
    write_reg("duty00_pins", 7'h04, 8'h00);
    count_level(3500, 1'b1, pin_hits, raw_hits);
    check("duty00_pin_high", pin_hits, 0);
    check("duty00_raw_high", raw_hits, 0);

    // Duty FF -> constant high
    write_reg("dutyFF_pins", 7'h04, 8'hFF);
    count_level(3500, 1'b0, pin_hits, raw_hits);
    check("dutyFF_pin_low", pin_hits, 0);
    check("dutyFF_raw_low", raw_hits, 0);

    // Reset mid-frame after 8 bits
    ncs = 1'b0;
    wait_clk(50);
    spi_bits({24'h0, 1'b1, 7'h01}, 8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_out_en = '0; m_pwm_en = '0; m_duty = '0;
    @(negedge clk);
    check("rst_mid_uo",  {24'h0, uo_out},   32'h00);
    check("rst_mid_uio", {24'h0, uio_out},  32'h00);
    check("rst_mid_pwm", {31'h0, pwm_bit0}, 32'h0);
    spi_bits({24'h0, 8'hFF}, 8);
    wait_clk(50);
    ncs = 1'b1;
    push_expect("rst_frame_dropped");
    wait_clk(20);
    pop_check();

    write_reg("post_rst_write", 7'h00, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #20ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
